// File: rtl/arith_pkg.sv
// Shared arithmetic-datapath types: divider FSM states and default operand width.
package arith_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} div_state_t;

  localparam int DIV_WIDTH = 4;

endpackage

// File: rtl/div_sub_stage.sv
// One restoring-division trial subtraction: a - {0,b} over WIDTH+1 bits using
// generate/propagate carries, reporting the low WIDTH diff bits and the borrow.
module div_sub_stage #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             borrow
);

  logic [WIDTH:0]   nb, g, p;
  logic [WIDTH+1:0] c;

  // a - b == a + ~b + 1; carry-out of 1 means no borrow
  assign nb   = {1'b1, ~b};
  assign g    = a & nb;
  assign p    = a | nb;
  assign c[0] = 1'b1;

  for (genvar i = 0; i <= WIDTH; i++) begin : g_carry
    assign c[i+1] = g[i] | (p[i] & c[i]);
  end

  // the top diff bit is always 0 when no borrow occurs, so it is not produced
  for (genvar i = 0; i < WIDTH; i++) begin : g_diff
    assign diff[i] = a[i] ^ nb[i] ^ c[i];
  end

  assign borrow = ~c[WIDTH+1];

endmodule

// File: rtl/seq_restoring_div.sv
// Multi-cycle unsigned restoring divider, one quotient bit per cycle MSB first,
// with valid/ready handshakes on operands and results.
module seq_restoring_div
  import arith_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH);

  div_state_t       state, nstate;
  logic [WIDTH-1:0] q, rem, dvs;
  logic             dbz;
  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rp;
  logic [WIDTH-1:0] diff;
  logic             borrow;
  logic             last;

  // rem is kept whole: with a large divisor its MSB can be set, so the shifted
  // partial remainder needs WIDTH+1 bits
  assign rp   = {rem, q[WIDTH-1]};
  assign last = (cnt == CW'(WIDTH - 1));

  div_sub_stage #(.WIDTH(WIDTH)) u_sub (
    .a      (rp),
    .b      (dvs),
    .diff   (diff),
    .borrow (borrow)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= nstate;
  end

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (in_valid) nstate = (divisor == '0) ? DONE : CALC;
      CALC:    if (last) nstate = DONE;
      DONE:    if (out_ready) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q   <= '0;
      rem <= '0;
      dvs <= '0;
      dbz <= 1'b0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          dvs <= divisor;
          cnt <= '0;
          if (divisor == '0) begin
            q   <= '1;
            rem <= dividend;
            dbz <= 1'b1;
          end else begin
            q   <= dividend;
            rem <= '0;
            dbz <= 1'b0;
          end
        end
        CALC: begin
          cnt <= cnt + 1'b1;
          q   <= {q[WIDTH-2:0], ~borrow};
          rem <= borrow ? rp[WIDTH-1:0] : diff;
        end
        default: ;
      endcase
    end
  end

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign quotient    = q;
  assign remainder   = rem;
  assign div_by_zero = dbz;

endmodule

// File: tb/tb_seq_restoring_div.sv
// Directed and exhaustive checks of seq_restoring_div at WIDTH=4.
module tb_seq_restoring_div;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic [3:0] dividend, divisor;
  logic       out_valid, out_ready;
  logic [3:0] quotient, remainder;
  logic       div_by_zero;

  int total = 0;
  int bad   = 0;

  seq_restoring_div #(.WIDTH(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .dividend    (dividend),
    .divisor     (divisor),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands, wait (bounded) for acceptance, then scramble the inputs.
  task automatic issue(input logic [3:0] a, input logic [3:0] b);
    int n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    chk("accept_ready", in_ready, 1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    tick();
    in_valid = 1'b0;
    dividend = ~a;
    divisor  = ~b;
    chk("busy_in_ready", in_ready, 0);
  endtask

  // Edges after the accepting edge until out_valid is seen (0 = next cycle).
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 50) begin
      tick();
      lat++;
    end
  endtask

  task automatic collect(input int hold, input logic [3:0] eq, input logic [3:0] er,
                         input logic edz);
    chk("out_valid", out_valid, 1);
    chk("quotient", quotient, eq);
    chk("remainder", remainder, er);
    chk("div_by_zero", div_by_zero, edz);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", out_valid, 1);
      chk("hold_q", quotient, eq);
      chk("hold_r", remainder, er);
      chk("hold_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_hs_valid", out_valid, 0);
    chk("post_hs_ready", in_ready, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    logic [3:0] eq, er;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; dividend = '0; divisor = '0;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    tick();
    rst = 1'b0;
    tick();

    // 13/3: result visible after the 4th edge following acceptance
    issue(4'd13, 4'd3);
    wait_done(lat);
    chk("lat_13_3", lat, 4);
    collect(0, 4'd4, 4'd1, 1'b0);

    issue(4'd15, 4'd1); wait_done(lat); chk("lat_15_1", lat, 4); collect(0, 4'd15, 4'd0, 1'b0);
    issue(4'd3,  4'd9); wait_done(lat); chk("lat_3_9",  lat, 4); collect(0, 4'd0,  4'd3, 1'b0);
    issue(4'd0,  4'd5); wait_done(lat); chk("lat_0_5",  lat, 4); collect(0, 4'd0,  4'd0, 1'b0);

    // divide by zero: result presented in the cycle right after the accepting edge
    issue(4'd7, 4'd0);
    wait_done(lat);
    chk("lat_dbz", lat, 0);
    collect(0, 4'd15, 4'd7, 1'b1);

    // back-pressure with stray in_valid pulses that must not be latched
    issue(4'd13, 4'd3);
    wait_done(lat);
    chk("lat_bp", lat, 4);
    for (int i = 0; i < 6; i++) begin
      in_valid = i[0];
      dividend = 4'd5;
      divisor  = 4'd1;
      tick();
      chk("bp_valid", out_valid, 1);
      chk("bp_q", quotient, 4);
      chk("bp_r", remainder, 1);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    collect(0, 4'd4, 4'd1, 1'b0);
    issue(4'd9, 4'd2); wait_done(lat); chk("lat_9_2", lat, 4); collect(0, 4'd4, 4'd1, 1'b0);

    // reset two cycles into CALC aborts the operation
    issue(4'd13, 4'd3);
    tick();
    rst = 1'b1;
    #1;
    chk("abort_in_ready", in_ready, 1);
    chk("abort_valid", out_valid, 0);
    chk("abort_q", quotient, 0);
    chk("abort_r", remainder, 0);
    chk("abort_dbz", div_by_zero, 0);
    tick();
    rst = 1'b0;
    tick();
    issue(4'd14, 4'd4); wait_done(lat); chk("lat_14_4", lat, 4); collect(0, 4'd3, 4'd2, 1'b0);

    // exhaustive sweep against integer division, random result back-pressure
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        eq = (b == 0) ? 4'd15 : 4'(a / b);
        er = (b == 0) ? 4'(a) : 4'(a % b);
        issue(4'(a), 4'(b));
        wait_done(lat);
        chk("sweep_lat", lat, (b == 0) ? 0 : 4);
        collect(int'($urandom_range(0, 3)), eq, er, b == 0);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
